// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory copy/fill engine.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } dmem_state_e;

   localparam int unsigned DMEM_STRIDE     = 4;
   localparam int unsigned DMEM_WORDS      = 256;
   localparam logic [1:0]  DMEM_ALIGN_MASK = 2'b00;

   function automatic logic dmem_is_aligned(input logic [1:0] lsb);
      return (lsb == DMEM_ALIGN_MASK);
   endfunction

endpackage

// File: rtl/dmem_copy_engine_if.sv
// Data-memory port between the copy engine (master) and the memory (slave).
interface dmem_bus_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] mem_access_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write_en;
   logic              mem_read;
   logic [DATA_W-1:0] mem_read_data;

   modport master (
      output mem_access_addr, mem_write_data, mem_write_en, mem_read,
      input  mem_read_data
   );

   modport slave (
      input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
      output mem_read_data
   );
endinterface

// File: rtl/dmem_addr_gen.sv
// Byte-address pointer with load/step and a remaining-word down-counter.
module dmem_addr_gen
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 9,
   parameter int STRIDE = DMEM_STRIDE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   output logic [ADDR_W-1:0] ptr,
   output logic [ADDR_W-1:0] next_ptr,
   output logic              last
);
   logic [ADDR_W-1:0] ptr_r;
   logic [LEN_W-1:0]  rem_r;

   assign ptr      = ptr_r;
   assign next_ptr = ptr_r + ADDR_W'(STRIDE);
   assign last     = (rem_r == LEN_W'(1));

   // Pointer and count: load wins over step; pointer wraps modulo 2^ADDR_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= {ADDR_W{1'b0}};
         rem_r <= {LEN_W{1'b0}};
      end else if (load) begin
         ptr_r <= load_addr;
         rem_r <= load_len;
      end else if (step) begin
         ptr_r <= next_ptr;
         rem_r <= rem_r - LEN_W'(1);
      end else begin
         ptr_r <= ptr_r;
         rem_r <= rem_r;
      end
   end
endmodule

// File: rtl/dmem_copy_engine.sv
// Word copy / fill engine on the data-memory port.
// Optional running write checksum output when DMEM_COPY_CHECKSUM_EN is defined.
module dmem_copy_engine
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 9,
   parameter int STRIDE = DMEM_STRIDE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              fill_mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic              error,
`ifdef DMEM_COPY_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   dmem_bus_if.master        bus
);
   dmem_state_e       state_r;
   logic              fill_r;
   logic [ADDR_W-1:0] src_ptr_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              rd_r;
   logic              we_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;
`ifdef DMEM_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] cks_r;
   assign checksum = cks_r;
`endif

   logic              accept_s;
   logic              misalign_s;
   logic [ADDR_W-1:0] dst_ptr_s;
   logic [ADDR_W-1:0] dst_next_s;
   logic              last_s;

   assign accept_s   = (state_r == IDLE) && start;
   assign misalign_s = (!fill_mode && !dmem_is_aligned(src_addr[1:0])) ||
                       !dmem_is_aligned(dst_addr[1:0]);

   dmem_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .STRIDE (STRIDE)
   ) u_dst_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept_s),
      .step      (state_r == WRITE),
      .load_addr (dst_addr),
      .load_len  (length),
      .ptr       (dst_ptr_s),
      .next_ptr  (dst_next_s),
      .last      (last_s)
   );

   assign busy                = busy_r;
   assign done                = done_r;
   assign error               = err_r;
   assign bus.mem_access_addr = addr_r;
   assign bus.mem_write_data  = wdata_r;
   assign bus.mem_write_en    = we_r;
   assign bus.mem_read        = rd_r;

   // Control FSM; bus outputs are set up on the edge entering READ/WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         fill_r    <= 1'b0;
         src_ptr_r <= {ADDR_W{1'b0}};
         addr_r    <= {ADDR_W{1'b0}};
         wdata_r   <= {DATA_W{1'b0}};
         rd_r      <= 1'b0;
         we_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
`ifdef DMEM_COPY_CHECKSUM_EN
         cks_r     <= {DATA_W{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  busy_r    <= 1'b1;
                  err_r     <= misalign_s;
                  fill_r    <= fill_mode;
                  src_ptr_r <= src_addr;
`ifdef DMEM_COPY_CHECKSUM_EN
                  cks_r     <= {DATA_W{1'b0}};
`endif
                  if (misalign_s || (length == {LEN_W{1'b0}})) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end else if (fill_mode) begin
                     state_r <= WRITE;
                     we_r    <= 1'b1;
                     addr_r  <= dst_addr;
                     wdata_r <= fill_value;
                  end else begin
                     state_r <= READ;
                     rd_r    <= 1'b1;
                     addr_r  <= src_addr;
                  end
               end
            end
            READ: begin
               state_r <= WRITE;
               rd_r    <= 1'b0;
               we_r    <= 1'b1;
               addr_r  <= dst_ptr_s;
               wdata_r <= bus.mem_read_data;
            end
            WRITE: begin
`ifdef DMEM_COPY_CHECKSUM_EN
               cks_r <= cks_r + wdata_r;
`endif
               if (!fill_r) begin
                  src_ptr_r <= src_ptr_r + ADDR_W'(STRIDE);
               end
               if (last_s) begin
                  state_r <= DONE;
                  we_r    <= 1'b0;
                  done_r  <= 1'b1;
               end else if (fill_r) begin
                  addr_r  <= dst_next_s;
               end else begin
                  state_r <= READ;
                  we_r    <= 1'b0;
                  rd_r    <= 1'b1;
                  addr_r  <= src_ptr_r + ADDR_W'(STRIDE);
               end
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               rd_r    <= 1'b0;
               we_r    <= 1'b0;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_copy_engine.sv
// Randomized self-checking bench for dmem_copy_engine against a word-level memory model.
module tb_dmem_copy_engine;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        fill_mode = 1'b0;
   logic [15:0] src_addr = 16'h0;
   logic [15:0] dst_addr = 16'h0;
   logic [8:0]  length = 9'h0;
   logic [15:0] fill_value = 16'h0;
   logic        busy, done, error;
`ifdef DMEM_COPY_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   dmem_bus_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   dmem_copy_engine dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .fill_mode  (fill_mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .error      (error),
`ifdef DMEM_COPY_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Memory: 256 words decoded from addr[9:2], combinational read.
   logic [15:0] mem [256];
   logic [15:0] ref_mem [256];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx = 8'h0;
   logic [15:0] pl_data = 16'h0;

   assign bus.mem_read_data = mem[bus.mem_access_addr[9:2]];

   always @(posedge clk) begin
      if (bus.mem_write_en) mem[bus.mem_access_addr[9:2]] <= bus.mem_write_data;
      else if (pl_en)       mem[pl_idx] <= pl_data;
   end

   int busy_cnt, done_cnt;
   logic [15:0] wq[$];
   logic [15:0] rq[$];

   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (bus.mem_write_en) wq.push_back(bus.mem_access_addr);
      if (bus.mem_read)     rq.push_back(bus.mem_access_addr);
   end

   int n_tests = 0;
   int n_fail  = 0;
   int op_id   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (op %0d): got %0h expected %0h", tag, op_id, got, exp);
      end
   endtask

   function automatic int widx(input logic [15:0] a, input int i);
      int unsigned x;
      x = (int'(a) + 4 * i) % 65536;
      return int'((x >> 2) % 256);
   endfunction

   task automatic preload_word(input int idx, input logic [15:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 8'(idx); pl_data = val;
      ref_mem[idx] = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      check_eq(tag, bad, 0);
   endtask

   task automatic run_cmd(input bit fm, input logic [15:0] s, input logic [15:0] d,
                          input int n, input logic [15:0] fv, input bit hammer);
      bit mis, seen;
      int exp_busy, exp_rd, exp_wr, bad;
      logic [15:0] exp_sum, v;
      logic [15:0] ea[$];
      logic [15:0] er[$];
      op_id++;
      mis = (!fm && s[1:0] != 2'b00) || (d[1:0] != 2'b00);
      exp_sum = 16'h0;
      if (mis || n == 0) begin
         exp_busy = 1; exp_rd = 0; exp_wr = 0;
      end else begin
         exp_wr = n; exp_rd = fm ? 0 : n; exp_busy = fm ? n + 1 : 2 * n + 1;
         for (int i = 0; i < n; i++) begin
            v = fm ? fv : ref_mem[widx(s, i)];
            ref_mem[widx(d, i)] = v;
            exp_sum = exp_sum + v;
            ea.push_back(d + 16'(4 * i));
            if (!fm) er.push_back(s + 16'(4 * i));
         end
      end
      @(negedge clk);
      busy_cnt = 0; done_cnt = 0; wq.delete(); rq.delete();
      start = 1'b1; fill_mode = fm; src_addr = s; dst_addr = d;
      length = 9'(n); fill_value = fv;
      @(negedge clk);
      if (!hammer) start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 1200; c++) begin
         if (done) begin seen = 1'b1; break; end
         if (hammer) begin
            fill_mode = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
            length = 9'($urandom); fill_value = 16'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      check_eq("done_seen", seen, 1);
      check_eq("error", error, mis);
      @(negedge clk);
      check_eq("busy_idle", busy, 0);
      check_eq("error_hold", error, mis);
      check_eq("done_cnt", done_cnt, 1);
      check_eq("busy_cnt", busy_cnt, exp_busy);
      check_eq("rd_cnt", rq.size(), exp_rd);
      check_eq("wr_cnt", wq.size(), exp_wr);
      bad = 0;
      for (int i = 0; i < wq.size() && i < ea.size(); i++) if (wq[i] !== ea[i]) bad++;
      for (int i = 0; i < rq.size() && i < er.size(); i++) if (rq[i] !== er[i]) bad++;
      check_eq("addr_seq", bad, 0);
`ifdef DMEM_COPY_CHECKSUM_EN
      check_eq("checksum", checksum, exp_sum);
`endif
      check_mem("mem");
   endtask

   initial begin
      bit seen;
      int k;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_outputs", {busy, done, error, bus.mem_write_en, bus.mem_read,
                               bus.mem_access_addr, bus.mem_write_data}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         pl_en = 1'b1; pl_idx = 8'(i);
         pl_data = (i < 3) ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
         ref_mem[i] = pl_data;
      end
      @(negedge clk);
      pl_en = 1'b0;

      // Directed cases.
      run_cmd(1'b0, 16'h0000, 16'h0100, 3, 16'h0, 1'b0);
      check_eq("copy_w0", mem[64], 16'h1111);
      check_eq("copy_w1", mem[65], 16'h2222);
      check_eq("copy_w2", mem[66], 16'h3333);
      run_cmd(1'b1, 16'h0040, 16'h0040, 4, 16'hBEEF, 1'b0);
      run_cmd(1'b0, 16'h0002, 16'h0100, 2, 16'h0, 1'b0);
      run_cmd(1'b0, 16'h0000, 16'h0200, 0, 16'h0, 1'b0);
      run_cmd(1'b1, 16'h0003, 16'h0041, 5, 16'h1234, 1'b0);
      run_cmd(1'b0, 16'h0020, 16'h0300, 5, 16'h0, 1'b1);
      preload_word(0, 16'h000A);
      preload_word(1, 16'h000B);
      preload_word(2, 16'h000C);
      run_cmd(1'b0, 16'h0000, 16'h0004, 3, 16'h0, 1'b0);
      check_eq("ovl_w1", mem[1], 16'h000A);
      check_eq("ovl_w3", mem[3], 16'h000A);
      run_cmd(1'b1, 16'h0000, 16'h0080, 3, 16'h8000, 1'b0);
`ifdef DMEM_COPY_CHECKSUM_EN
      check_eq("cks_8000", checksum, 16'h8000);
`endif
      run_cmd(1'b1, 16'h0000, 16'hFFF8, 4, 16'h5A5A, 1'b0);

      // Reset during the second write of a 4-word copy.
      op_id++;
      @(negedge clk);
      start = 1'b1; fill_mode = 1'b0; src_addr = 16'h0300; dst_addr = 16'h0380;
      length = 9'd4;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0; k = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.mem_write_en) begin
            k++;
            if (k == 2) begin seen = 1'b1; break; end
         end
         @(negedge clk);
      end
      check_eq("rst_wait", seen, 1);
      ref_mem[widx(16'h0380, 0)] = ref_mem[widx(16'h0300, 0)];
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_async", {busy, done, error, bus.mem_write_en, bus.mem_read,
                             bus.mem_access_addr, bus.mem_write_data}, 0);
      done_cnt = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_no_done", done_cnt, 0);
      check_eq("rst_idle", busy, 0);
      check_mem("rst_mem");

      // Randomized commands.
      for (int t = 0; t < 40; t++) begin
         logic [15:0] s, d;
         s = 16'($urandom); d = 16'($urandom);
         if ($urandom_range(0, 5) != 0) s[1:0] = 2'b00;
         if ($urandom_range(0, 5) != 0) d[1:0] = 2'b00;
         run_cmd(1'($urandom), s, d, int'($urandom_range(0, 24)), 16'($urandom),
                 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
